// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: the bundle of signals around the shared-ALU arbiter.
//   Requester side : req, op_in, a_in, b_in (in); gnt (out)
//   ALU side       : alu_in1, alu_in2, alu_s, alu_ld (out); alu_out (in)
//   Response side  : rsp_valid, rsp_id, rsp_data (out); rsp_ready (in)
//   Status         : busy (out)
// The slave modport is the arbiter itself. The master modport is everything around it:
// clients, the ALU and the response consumer.
interface alu_req_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*3-1:0] op_in;
    logic [NREQ*4-1:0] a_in;
    logic [NREQ*4-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [3:0]        alu_in1;
    logic [3:0]        alu_in2;
    logic [2:0]        alu_s;
    logic              alu_ld;
    logic [7:0]        alu_out;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_ready;
    logic              busy;

    modport slave (
        input  req, op_in, a_in, b_in, alu_out, rsp_ready,
        output gnt, alu_in1, alu_in2, alu_s, alu_ld, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req, op_in, a_in, b_in, alu_out, rsp_ready,
        input  gnt, alu_in1, alu_in2, alu_s, alu_ld, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one 4-bit, 8-function ALU among NREQ requesters.
// A round-robin pick in IDLE grants one requester and latches its op and operands. LOAD
// pulses the ALU's ld. WAIT covers the op's latency and captures alu_out. RESP holds the
// result under a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - alu_req_arbiter_if.slave (request, ALU, response and busy signals)
module alu_req_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned CNT_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    alu_req_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(CNT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      id_q, id_d;
    logic [2:0]      op_q, op_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [7:0]      data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [1:0]      scan_idx;
    logic [2:0]      win_op;
    logic [3:0]      win_a;
    logic [3:0]      win_b;

    // Round-robin: scan from the slot after the last served requester, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            scan_idx = 2'((32'(last_q) + i) % NREQ);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(win_idx) == i) begin
                win_op = bus.op_in[3*i +: 3];
                win_a  = bus.a_in[4*i +: 4];
                win_b  = bus.b_in[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    id_d    = win_idx;
                    op_d    = win_op;
                    a_d     = win_a;
                    b_d     = win_b;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Counter ops need the ALU to step for several cycles before capture.
                cnt_d   = (op_q == 3'b101 || op_q == 3'b110) ? CntW'(CNT_CYCLES) : CntW'(1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CntW'(1)) begin
                    data_d  = bus.alu_out;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    last_d  = id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 2'(NREQ - 1);
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // A grant cannot be honoured while reset holds the latches, so it is suppressed too.
    assign bus.gnt       = (rst && state_q == StIdle && win_found) ?
                           (NREQ'(1) << win_idx) : '0;
    assign bus.alu_ld    = (state_q == StLoad);
    assign bus.alu_in1   = a_q;
    assign bus.alu_in2   = b_q;
    assign bus.alu_s     = op_q;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
